// File: rtl/tagged_arbitrated_fifos.sv
// Bank of tagged circular FIFOs with a full-aware push redirector, a round-robin pop arbiter
// and a registered output stage. Define TAGGED_FIFO_REDIRECT_EN to enable push redirection.
module tagged_arbitrated_fifos #(
  parameter int NUM_FIFOS = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int TAGWIDTH  = $clog2(NUM_FIFOS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_valid,
  input  logic [TAGWIDTH-1:0]  push_sel,
  input  logic [WIDTH-1:0]     data_in,
  output logic                 push_ready,
  output logic                 redirected,
  input  logic [NUM_FIFOS-1:0] reqs,
  output logic [NUM_FIFOS-1:0] gnt,
  output logic [NUM_FIFOS-1:0] full,
  output logic [NUM_FIFOS-1:0] empty,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     data_out,
  output logic [TAGWIDTH-1:0]  tag_out,
  output logic [TAGWIDTH-1:0]  src_out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = TAGWIDTH + WIDTH;

  logic [NUM_FIFOS-1:0] push_we;
  logic [NUM_FIFOS-1:0] eligible;
  logic [TAGWIDTH-1:0]  target;
  logic                 target_ok;
  logic [TAGWIDTH-1:0]  gnt_idx;
  logic                 gnt_found;
  logic [TAGWIDTH-1:0]  last_gnt_q, last_gnt_d;
  logic [EW-1:0]        rd_entry [NUM_FIFOS];

  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    data_out_q, data_out_d;
  logic [TAGWIDTH-1:0] tag_out_q, tag_out_d;
  logic [TAGWIDTH-1:0] src_out_q, src_out_d;

  // Push target: requested FIFO, or the next non-full one above it (wrapping) when redirecting.
  always_comb begin
    target    = '0;
    target_ok = 1'b0;
    if (int'(push_sel) < NUM_FIFOS) begin
`ifdef TAGGED_FIFO_REDIRECT_EN
      for (int pass = 0; pass < 2; pass++) begin
        for (int i = 0; i < NUM_FIFOS; i++) begin
          if (!target_ok && ((pass == 0) == (i >= int'(push_sel))) && !full[i]) begin
            target    = TAGWIDTH'(i);
            target_ok = 1'b1;
          end
        end
      end
`else
      for (int i = 0; i < NUM_FIFOS; i++) begin
        if ((i == int'(push_sel)) && !full[i]) begin
          target    = TAGWIDTH'(i);
          target_ok = 1'b1;
        end
      end
`endif
    end
  end

  assign push_ready = target_ok;
  assign push_we    = (push_valid && target_ok) ? (NUM_FIFOS'(1) << target) : '0;

`ifdef TAGGED_FIFO_REDIRECT_EN
  assign redirected = push_valid && target_ok && (target != push_sel);
`else
  assign redirected = 1'b0;
`endif

  // Round-robin: first eligible index strictly after last_gnt, wrapping.
  always_comb begin
    eligible  = reqs & ~empty;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < NUM_FIFOS; i++) begin
        if (!gnt_found && ((pass == 0) == (i > int'(last_gnt_q))) && eligible[i]) begin
          gnt[i]    = 1'b1;
          gnt_idx   = TAGWIDTH'(i);
          gnt_found = 1'b1;
        end
      end
    end
    last_gnt_d = gnt_found ? gnt_idx : last_gnt_q;
  end

  always_comb begin
    out_valid_d = gnt_found;
    data_out_d  = data_out_q;
    tag_out_d   = tag_out_q;
    src_out_d   = src_out_q;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (gnt[i]) begin
        {tag_out_d, data_out_d} = rd_entry[i];
        src_out_d               = TAGWIDTH'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q  <= TAGWIDTH'(NUM_FIFOS - 1);
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      tag_out_q   <= '0;
      src_out_q   <= '0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      tag_out_q   <= tag_out_d;
      src_out_q   <= src_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign tag_out   = tag_out_q;
  assign src_out   = src_out_q;

  for (genvar gi = 0; gi < NUM_FIFOS; gi++) begin : g_fifo
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [EW-1:0] mem [DEPTH];

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_we[gi]) begin
        wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (gnt[gi]) begin
        rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      case ({push_we[gi], gnt[gi]})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    // Storage needs no reset: occupancy counters alone decide what is valid.
    always_ff @(posedge clk) begin
      if (push_we[gi]) begin
        mem[wr_ptr_q] <= {push_sel, data_in};
      end
    end

    assign rd_entry[gi] = mem[rd_ptr_q];
    assign full[gi]     = (count_q == CW'(DEPTH));
    assign empty[gi]    = (count_q == '0);
  end

endmodule

// File: tb/tb_tagged_arbitrated_fifos.sv
// Randomized, model-checked bench for tagged_arbitrated_fifos (both redirect configurations).
module tb_tagged_arbitrated_fifos;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          push_valid;
  logic [TW-1:0] push_sel;
  logic [W-1:0]  data_in;
  logic          push_ready;
  logic          redirected;
  logic [N-1:0]  reqs;
  logic [N-1:0]  gnt;
  logic [N-1:0]  full;
  logic [N-1:0]  empty;
  logic          out_valid;
  logic [W-1:0]  data_out;
  logic [TW-1:0] tag_out;
  logic [TW-1:0] src_out;

  int total = 0;
  int bad   = 0;

  // Reference model: one queue of {tag,data} per FIFO plus expected output register.
  logic [TW+W-1:0] mq [N][$];
  int              last_m;
  bit              ov_m;
  logic [W-1:0]    do_m;
  int              tag_m;
  int              src_m;

  tagged_arbitrated_fifos #(
    .NUM_FIFOS(N), .WIDTH(W), .DEPTH(D), .TAGWIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst), .push_valid(push_valid), .push_sel(push_sel), .data_in(data_in),
    .push_ready(push_ready), .redirected(redirected), .reqs(reqs), .gnt(gnt), .full(full),
    .empty(empty), .out_valid(out_valid), .data_out(data_out), .tag_out(tag_out), .src_out(src_out)
  );

  always #5 clk = ~clk;

  function automatic int m_target();
    int s;
    s = int'(push_sel);
    if (s >= N) return -1;
`ifdef TAGGED_FIFO_REDIRECT_EN
    for (int k = 0; k < N; k++) begin
      if (mq[(s + k) % N].size() < D) return (s + k) % N;
    end
    return -1;
`else
    return (mq[s].size() < D) ? s : -1;
`endif
  endfunction

  function automatic int m_gnt();
    for (int k = 1; k <= N; k++) begin
      if (reqs[(last_m + k) % N] && mq[(last_m + k) % N].size() > 0) return (last_m + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_full();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (mq[i].size() == D);
    return v;
  endfunction

  function automatic logic [N-1:0] m_empty();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (mq[i].size() == 0);
    return v;
  endfunction

  task automatic model_clock();
    int t;
    int g;
    logic [TW+W-1:0] e;
    t = m_target();
    g = m_gnt();
    if (g >= 0) begin
      e      = mq[g].pop_front();
      ov_m   = 1'b1;
      do_m   = e[W-1:0];
      tag_m  = int'(e[TW+W-1:W]);
      src_m  = g;
      last_m = g;
    end else begin
      ov_m = 1'b0;
    end
    if (push_valid && t >= 0) mq[t].push_back({push_sel, data_in});
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    push_valid = 1'b0;
    push_sel   = '0;
    data_in    = '0;
    reqs       = '0;
    for (int i = 0; i < N; i++) mq[i].delete();
    last_m = N - 1;
    ov_m   = 1'b0;
    do_m   = '0;
    tag_m  = 0;
    src_m  = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic push_one(input int sel, input logic [W-1:0] d);
    push_valid = 1'b1;
    push_sel   = TW'(sel);
    data_in    = d;
    reqs       = '0;
    tick();
    push_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reqs = 4'b1111;
    @(negedge clk);
    total++; if (empty !== 4'b1111) begin bad++; $display("FAIL reset_empty got=%b exp=1111", empty); end
    total++; if (full !== 4'b0000) begin bad++; $display("FAIL reset_full got=%b exp=0000", full); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if ({data_out, tag_out, src_out} !== 12'h000) begin bad++; $display("FAIL reset_out_regs got=%h/%0d/%0d exp=0/0/0", data_out, tag_out, src_out); end
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt_all_empty got=%b exp=0000", gnt); end
    total++; if (redirected !== 1'b0 || push_ready !== 1'b1) begin bad++; $display("FAIL reset_push got rdy=%b redir=%b exp rdy=1 redir=0", push_ready, redirected); end
    $display("test_reset done");
    tick();
  endtask

  task automatic test_basic();
    do_reset();
    push_valid = 1'b1; push_sel = 2'd2; data_in = 8'hA5; reqs = 4'b0100;
    @(negedge clk);
    total++; if (push_ready !== 1'b1 || gnt !== 4'b0000) begin bad++; $display("FAIL basic_push got rdy=%b gnt=%b exp rdy=1 gnt=0000", push_ready, gnt); end
    tick();
    push_valid = 1'b0;
    @(negedge clk);
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL basic_gnt got=%b exp=0100", gnt); end
    tick();
    reqs = '0;
    @(negedge clk);
    total++; if ({out_valid, data_out, tag_out, src_out} !== {1'b1, 8'hA5, 2'd2, 2'd2}) begin
      bad++; $display("FAIL basic_out got v=%b d=%h t=%0d s=%0d exp v=1 d=a5 t=2 s=2", out_valid, data_out, tag_out, src_out);
    end
    $display("test_basic done");
    tick();
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < D; i++) push_one(1, W'(8'h50 + i));
    push_valid = 1'b1; push_sel = 2'd1; data_in = 8'h3C;
    @(negedge clk);
    total++; if (full !== 4'b0010) begin bad++; $display("FAIL redir_full got=%b exp=0010", full); end
`ifdef TAGGED_FIFO_REDIRECT_EN
    total++; if (push_ready !== 1'b1 || redirected !== 1'b1) begin bad++; $display("FAIL redir_flags got rdy=%b redir=%b exp 1/1", push_ready, redirected); end
    tick();
    push_valid = 1'b0; reqs = 4'b0100;
    @(negedge clk);
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL redir_gnt got=%b exp=0100", gnt); end
    tick();
    reqs = '0;
    @(negedge clk);
    total++; if ({out_valid, data_out, tag_out, src_out} !== {1'b1, 8'h3C, 2'd1, 2'd2}) begin
      bad++; $display("FAIL redir_out got v=%b d=%h t=%0d s=%0d exp v=1 d=3c t=1 s=2", out_valid, data_out, tag_out, src_out);
    end
`else
    total++; if (push_ready !== 1'b0 || redirected !== 1'b0) begin bad++; $display("FAIL redir_off_flags got rdy=%b redir=%b exp 0/0", push_ready, redirected); end
    tick();
    push_valid = 1'b0;
    @(negedge clk);
    total++; if (empty !== 4'b1101) begin bad++; $display("FAIL redir_off_empty got=%b exp=1101", empty); end
`endif
    $display("test_redirect done");
    tick();
  endtask

  task automatic test_all_full();
    do_reset();
    for (int i = 0; i < N * D; i++) push_one(i / D, W'(i));
    push_valid = 1'b1; push_sel = TW'($urandom_range(0, N - 1)); data_in = 8'hEE;
    @(negedge clk);
    total++; if (push_ready !== 1'b0 || full !== 4'b1111) begin bad++; $display("FAIL allfull_ready got rdy=%b full=%b exp rdy=0 full=1111", push_ready, full); end
    tick();
    push_valid = 1'b0; reqs = 4'b1000;
    @(negedge clk);
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL allfull_gnt got=%b exp=1000", gnt); end
    tick();
    reqs = '0; push_valid = 1'b1; push_sel = 2'd0; data_in = 8'h99;
    @(negedge clk);
    total++; if (full !== 4'b0111 || {data_out, src_out} !== {8'd12, 2'd3}) begin
      bad++; $display("FAIL allfull_pop got full=%b d=%h s=%0d exp full=0111 d=0c s=3", full, data_out, src_out);
    end
`ifdef TAGGED_FIFO_REDIRECT_EN
    total++; if (push_ready !== 1'b1 || redirected !== 1'b1) begin bad++; $display("FAIL allfull_redir got rdy=%b redir=%b exp 1/1", push_ready, redirected); end
`else
    total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL allfull_noredir got rdy=%b exp 0", push_ready); end
`endif
    tick();
    push_valid = 1'b0;
    @(negedge clk);
    total++; if (full !== m_full()) begin bad++; $display("FAIL allfull_after got=%b exp=%b", full, m_full()); end
    $display("test_all_full done");
    tick();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    do_reset();
    for (int i = 0; i < 2 * N; i++) push_one(i / 2, W'(8'h80 + i));
    reqs = 4'b1111;
    for (int c = 0; c < 2 * N; c++) begin
      @(negedge clk);
      exp_g = 4'b0001 << (c % N);
      total++; if (gnt !== exp_g) begin bad++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", c, gnt, exp_g); end
      tick();
    end
    @(negedge clk);
    total++; if (gnt !== 4'b0000 || empty !== 4'b1111) begin bad++; $display("FAIL rr_drained got gnt=%b empty=%b exp 0000/1111", gnt, empty); end
    total++; if ({out_valid, data_out, src_out} !== {1'b1, 8'h87, 2'd3}) begin bad++; $display("FAIL rr_last_out got v=%b d=%h s=%0d exp v=1 d=87 s=3", out_valid, data_out, src_out); end
    tick();
    reqs = '0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rr_idle_valid got=%b exp=0", out_valid); end
    $display("test_round_robin done");
    tick();
  endtask

  task automatic test_full_push_pop();
    int pops;
    do_reset();
    for (int i = 0; i < D; i++) push_one(0, W'(8'h10 + i));
    push_valid = 1'b1; push_sel = 2'd0; data_in = 8'h77; reqs = 4'b0001;
    @(negedge clk);
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL fpp_gnt got=%b exp=0001", gnt); end
`ifdef TAGGED_FIFO_REDIRECT_EN
    total++; if (push_ready !== 1'b1 || redirected !== 1'b1) begin bad++; $display("FAIL fpp_redir got rdy=%b redir=%b exp 1/1", push_ready, redirected); end
`else
    total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL fpp_refuse got rdy=%b exp 0", push_ready); end
`endif
    tick();
    push_valid = 1'b0; reqs = '0;
    @(negedge clk);
`ifdef TAGGED_FIFO_REDIRECT_EN
    total++; if (empty !== 4'b1100 || full !== 4'b0000) begin bad++; $display("FAIL fpp_state got empty=%b full=%b exp 1100/0000", empty, full); end
`else
    total++; if (empty !== 4'b1110 || full !== 4'b0000) begin bad++; $display("FAIL fpp_state got empty=%b full=%b exp 1110/0000", empty, full); end
`endif
    tick();
    pops = 0;
    reqs = 4'b0001;
    for (int c = 0; c < 2 * D; c++) begin
      @(negedge clk);
      if (gnt[0]) pops++;
      tick();
    end
    reqs = '0;
    total++; if (pops != 3) begin bad++; $display("FAIL fpp_occupancy got=%0d exp=3", pops); end
    $display("test_full_push_pop done");
  endtask

  task automatic test_random();
    int t;
    int g;
    logic [N-1:0] eg;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      push_valid = ($urandom_range(0, 3) != 0);
      push_sel   = TW'($urandom_range(0, N - 1));
      data_in    = W'($urandom);
      reqs       = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      @(negedge clk);
      t = m_target();
      g = m_gnt();
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      total++; if (push_ready !== (t >= 0)) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, push_ready, (t >= 0)); end
      total++; if (redirected !== (push_valid && t >= 0 && t != int'(push_sel))) begin bad++; $display("FAIL rand_redir cyc=%0d got=%b", c, redirected); end
      total++; if (gnt !== eg) begin bad++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", c, gnt, eg); end
      total++; if (full !== m_full() || empty !== m_empty()) begin bad++; $display("FAIL rand_flags cyc=%0d got f=%b e=%b exp f=%b e=%b", c, full, empty, m_full(), m_empty()); end
      total++; if (out_valid !== ov_m) begin bad++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, out_valid, ov_m); end
      if (ov_m) begin
        total++; if (data_out !== do_m || int'(tag_out) != tag_m || int'(src_out) != src_m) begin
          bad++; $display("FAIL rand_out cyc=%0d got d=%h t=%0d s=%0d exp d=%h t=%0d s=%0d", c, data_out, tag_out, src_out, do_m, tag_m, src_m);
        end
      end
      tick();
    end
    push_valid = 1'b0; reqs = '0;
    $display("test_random done");
  endtask

  task automatic test_async_reset();
    do_reset();
    push_one(0, 8'h11);
    push_one(0, 8'h22);
    push_one(2, 8'h33);
    reqs = 4'b0001;
    tick();
    reqs = '0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || data_out !== 8'h11) begin bad++; $display("FAIL areset_pre got v=%b d=%h exp v=1 d=11", out_valid, data_out); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || data_out !== 8'h00) begin bad++; $display("FAIL areset_out got v=%b d=%h exp v=0 d=00", out_valid, data_out); end
    total++; if (empty !== 4'b1111 || full !== 4'b0000) begin bad++; $display("FAIL areset_flags got e=%b f=%b exp 1111/0000", empty, full); end
    do_reset();
    $display("test_async_reset done");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; push_valid = 1'b0; push_sel = '0; data_in = '0; reqs = '0;
    test_reset();
    test_basic();
    test_redirect();
    test_all_full();
    test_round_robin();
    test_full_push_pop();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
